reg_xfer_seq: RTL and testbench

Sequencer for the 6502 internal register-transfer datapath. Accepts one decoded implied-mode opcode from the instruction decoder. Drives the load and bus-enable strobes of the X, Y, ACC, S, AI and BI registers over the SB/DB buses to execute the transfer and increment/decrement instructions (TAX, TXA, TAY, TYA, TSX, TXS, INX, INY, DEX, DEY). Sits between the decoder/timing logic and the register file.

---
 rtl/reg_xfer_seq_if.sv | 42 ++++
 rtl/reg_xfer_seq.sv | 137 +++++++++++++
 tb/tb_reg_xfer_seq.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_xfer_seq_if.sv
// reg_xfer_seq_if: handshake and strobe bundle between the decoder/timing logic
// and the register-transfer sequencer.
//   master: decoder side, drives start/opcode/rdy and observes the strobes.
//   slave : sequencer side, samples start/opcode/rdy and drives the strobes.
interface reg_xfer_seq_if;
  logic       start;
  logic [7:0] opcode;
  logic       rdy;
  logic       busy;
  logic       done;
  logic       illegal;
  logic       nz_update;
  logic       x_load;
  logic       x_bus_enable;
  logic       y_load;
  logic       y_bus_enable;
  logic       acc_load;
  logic       acc_sb_enable;
  logic       daa_pass;
  logic       s_sb_load;
  logic       s_sb_enable;
  logic       ai_sb_load;
  logic       bi_db_load;
  logic       bi_inv_db_load;
  logic       const_db_enable;
  logic       alu_ci;
  logic       add_sb_enable;

  modport master (
    output start, opcode, rdy,
    input  busy, done, illegal, nz_update, x_load, x_bus_enable, y_load, y_bus_enable,
    input  acc_load, acc_sb_enable, daa_pass, s_sb_load, s_sb_enable, ai_sb_load,
    input  bi_db_load, bi_inv_db_load, const_db_enable, alu_ci, add_sb_enable
  );

  modport slave (
    input  start, opcode, rdy,
    output busy, done, illegal, nz_update, x_load, x_bus_enable, y_load, y_bus_enable,
    output acc_load, acc_sb_enable, daa_pass, s_sb_load, s_sb_enable, ai_sb_load,
    output bi_db_load, bi_inv_db_load, const_db_enable, alu_ci, add_sb_enable
  );
endinterface

// File: rtl/reg_xfer_seq.sv
// reg_xfer_seq: sequencer for the 6502 register-transfer datapath. Executes
// TAX/TXA/TAY/TYA/TSX/TXS in one strobe cycle and INX/INY/DEX/DEY in two
// (load ALU inputs, then write back the ALU result).
// Ports:
//   clk - system clock, rising edge
//   rst - asynchronous active-high reset
//   bus - slave side of reg_xfer_seq_if (start/opcode/rdy in, strobes out)
// All strobes are Moore-decoded from the state and latched opcode, gated by rdy.
module reg_xfer_seq (
  input logic           clk,
  input logic           rst,
  reg_xfer_seq_if.slave bus
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StXfer  = 2'd1;
  localparam logic [1:0] StAluLd = 2'd2;
  localparam logic [1:0] StAluWb = 2'd3;

  localparam logic [1:0] RegX = 2'd0;
  localparam logic [1:0] RegY = 2'd1;
  localparam logic [1:0] RegA = 2'd2;
  localparam logic [1:0] RegS = 2'd3;

  logic [1:0] state_q, state_d;
  logic [1:0] src_q, src_d;
  logic [1:0] dst_q, dst_d;
  logic       inc_q, inc_d;
  logic       nz_q, nz_d;
  logic       illegal_q, illegal_d;

  // Opcode decode
  logic       dec_valid, dec_alu, dec_inc, dec_nz;
  logic [1:0] dec_src, dec_dst;

  always_comb begin
    dec_valid = 1'b1;
    dec_alu   = 1'b0;
    dec_inc   = 1'b0;
    dec_nz    = 1'b1;
    dec_src   = RegX;
    dec_dst   = RegX;
    case (bus.opcode)
      8'hAA: begin dec_src = RegA; dec_dst = RegX; end
      8'h8A: begin dec_src = RegX; dec_dst = RegA; end
      8'hA8: begin dec_src = RegA; dec_dst = RegY; end
      8'h98: begin dec_src = RegY; dec_dst = RegA; end
      8'hBA: begin dec_src = RegS; dec_dst = RegX; end
      8'h9A: begin dec_src = RegX; dec_dst = RegS; dec_nz = 1'b0; end
      8'hE8: begin dec_src = RegX; dec_dst = RegX; dec_alu = 1'b1; dec_inc = 1'b1; end
      8'hC8: begin dec_src = RegY; dec_dst = RegY; dec_alu = 1'b1; dec_inc = 1'b1; end
      8'hCA: begin dec_src = RegX; dec_dst = RegX; dec_alu = 1'b1; end
      8'h88: begin dec_src = RegY; dec_dst = RegY; dec_alu = 1'b1; end
      default: dec_valid = 1'b0;
    endcase
  end

  // Next state; rdy low holds every non-idle state in place
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    inc_d     = inc_q;
    nz_d      = nz_q;
    illegal_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (dec_valid) begin
            state_d = dec_alu ? StAluLd : StXfer;
            src_d   = dec_src;
            dst_d   = dec_dst;
            inc_d   = dec_inc;
            nz_d    = dec_nz;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      StXfer:  if (bus.rdy) state_d = StIdle;
      StAluLd: if (bus.rdy) state_d = StAluWb;
      StAluWb: if (bus.rdy) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      src_q     <= RegX;
      dst_q     <= RegX;
      inc_q     <= 1'b0;
      nz_q      <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      inc_q     <= inc_d;
      nz_q      <= nz_d;
      illegal_q <= illegal_d;
    end
  end

  // Output decode
  logic go, in_ld, in_wb, src_en, dst_ld, alu_phase;

  assign go        = (state_q != StIdle) && bus.rdy;
  assign in_ld     = go && (state_q == StAluLd);
  assign in_wb     = go && (state_q == StAluWb);
  assign src_en    = go && ((state_q == StXfer) || (state_q == StAluLd));
  assign dst_ld    = go && ((state_q == StXfer) || (state_q == StAluWb));
  // Carry-in is not a strobe: it stays valid through a stall
  assign alu_phase = (state_q == StAluLd) || (state_q == StAluWb);

  assign bus.busy            = (state_q != StIdle);
  assign bus.illegal         = illegal_q;
  assign bus.done            = dst_ld;
  assign bus.nz_update       = dst_ld && nz_q;
  assign bus.x_bus_enable    = src_en && (src_q == RegX);
  assign bus.y_bus_enable    = src_en && (src_q == RegY);
  assign bus.acc_sb_enable   = src_en && (src_q == RegA);
  assign bus.s_sb_enable     = src_en && (src_q == RegS);
  assign bus.x_load          = dst_ld && (dst_q == RegX);
  assign bus.y_load          = dst_ld && (dst_q == RegY);
  assign bus.acc_load        = dst_ld && (dst_q == RegA);
  assign bus.daa_pass        = dst_ld && (dst_q == RegA);
  assign bus.s_sb_load       = dst_ld && (dst_q == RegS);
  assign bus.ai_sb_load      = in_ld;
  assign bus.const_db_enable = in_ld;
  // BI = 0x00 with ci=1 gives +1; BI = 0xFF with ci=0 gives -1
  assign bus.bi_db_load      = in_ld && inc_q;
  assign bus.bi_inv_db_load  = in_ld && !inc_q;
  assign bus.alu_ci          = alu_phase && inc_q;
  assign bus.add_sb_enable   = in_wb;

endmodule

// File: tb/tb_reg_xfer_seq.sv
module tb_reg_xfer_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_xfer_seq_if bus ();

  reg_xfer_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Strobe vector bit masks
  localparam logic [17:0] M_ADD  = 18'h00001;
  localparam logic [17:0] M_CI   = 18'h00002;
  localparam logic [17:0] M_CDB  = 18'h00004;
  localparam logic [17:0] M_BINV = 18'h00008;
  localparam logic [17:0] M_BI   = 18'h00010;
  localparam logic [17:0] M_AI   = 18'h00020;
  localparam logic [17:0] M_SEN  = 18'h00040;
  localparam logic [17:0] M_SLD  = 18'h00080;
  localparam logic [17:0] M_DAA  = 18'h00100;
  localparam logic [17:0] M_AEN  = 18'h00200;
  localparam logic [17:0] M_ALD  = 18'h00400;
  localparam logic [17:0] M_YEN  = 18'h00800;
  localparam logic [17:0] M_YLD  = 18'h01000;
  localparam logic [17:0] M_XEN  = 18'h02000;
  localparam logic [17:0] M_XLD  = 18'h04000;
  localparam logic [17:0] M_NZ   = 18'h08000;
  localparam logic [17:0] M_DONE = 18'h10000;
  localparam logic [17:0] M_ILL  = 18'h20000;

  typedef struct {
    string       name;
    logic [17:0] vec;
    int          cyc;
    logic        chk_val;
    logic [7:0]  val;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [17:0] observe();
    return {bus.illegal, bus.done, bus.nz_update, bus.x_load, bus.x_bus_enable, bus.y_load,
            bus.y_bus_enable, bus.acc_load, bus.acc_sb_enable, bus.daa_pass, bus.s_sb_load,
            bus.s_sb_enable, bus.ai_sb_load, bus.bi_db_load, bus.bi_inv_db_load,
            bus.const_db_enable, bus.alu_ci, bus.add_sb_enable};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Datapath model: registers, SB/DB buses and the ALU adder
  logic [7:0] m_x, m_y, m_a, m_s, m_ai, m_bi, sb, db;
  logic [7:0] set_x, set_y, set_a, set_s;
  logic       set_req = 1'b0;
  int         y_loads = 0;

  always_comb begin
    db = bus.const_db_enable ? 8'h00 : 8'hFF;
    sb = 8'hFF;
    if (bus.x_bus_enable)       sb = m_x;
    else if (bus.y_bus_enable)  sb = m_y;
    else if (bus.acc_sb_enable) sb = m_a;
    else if (bus.s_sb_enable)   sb = m_s;
    else if (bus.add_sb_enable) sb = m_ai + m_bi + {7'd0, bus.alu_ci};
  end

  always @(posedge clk) begin
    if (set_req) begin
      m_x <= set_x;
      m_y <= set_y;
      m_a <= set_a;
      m_s <= set_s;
    end else begin
      if (bus.x_load) m_x <= sb;
      if (bus.y_load) m_y <= sb;
      if (bus.acc_load && bus.daa_pass) m_a <= sb;
      if (bus.s_sb_load) m_s <= sb;
      if (bus.ai_sb_load) m_ai <= sb;
      if (bus.bi_db_load) m_bi <= db;
      if (bus.bi_inv_db_load) m_bi <= ~db;
    end
    if (bus.y_load) y_loads <= y_loads + 1;
  end

  // Monitor: pops an expectation whenever any strobe (other than the held carry-in) shows
  logic [17:0] obs;
  exp_t        e;
  always @(negedge clk) begin
    if (!rst) begin
      obs = observe();
      if ((obs & ~M_CI) != 18'd0) begin
        if (q.size() == 0) begin
          chk("unexpected_strobe", {14'd0, obs}, 32'd0);
        end else begin
          e = q.pop_front();
          chk({e.name, "_vec"}, {14'd0, obs}, {14'd0, e.vec});
          chk({e.name, "_cyc"}, cyc, e.cyc);
          if (e.chk_val) chk({e.name, "_val"}, {24'd0, sb}, {24'd0, e.val});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] x, input logic [7:0] y, input logic [7:0] a,
                         input logic [7:0] s);
    set_x = x; set_y = y; set_a = a; set_s = s;
    set_req = 1'b1;
    tick();
    set_req = 1'b0;
  endtask

  task automatic push(input string name, input logic [17:0] vec, input int c,
                      input logic chk_val, input logic [7:0] val);
    exp_t t;
    t.name = name; t.vec = vec; t.cyc = c; t.chk_val = chk_val; t.val = val;
    q.push_back(t);
  endtask

  task automatic issue(input logic [7:0] op);
    bus.start  = 1'b1;
    bus.opcode = op;
    tick();
    bus.start  = 1'b0;
    bus.opcode = 8'h00;
  endtask

  task automatic xfer(input string name, input logic [7:0] op, input logic [17:0] vec,
                      input logic [7:0] val);
    push(name, vec, cyc + 1, 1'b1, val);
    issue(op);
    chk({name, "_busy"}, {31'd0, bus.busy}, 32'd1);
    tick();
    chk({name, "_idle"}, {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic incdec(input string name, input logic [7:0] op, input logic [17:0] ldv,
                        input logic [17:0] wbv, input logic [7:0] val);
    push({name, "_ld"}, ldv, cyc + 1, 1'b0, 8'h00);
    push({name, "_wb"}, wbv, cyc + 2, 1'b1, val);
    issue(op);
    tick();
    chk({name, "_busy_wb"}, {31'd0, bus.busy}, 32'd1);
    tick();
    chk({name, "_idle"}, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int y_before;

  initial begin
    bus.start  = 1'b0;
    bus.opcode = 8'h00;
    bus.rdy    = 1'b1;
    repeat (2) tick();
    chk("reset_outputs", {13'd0, observe(), bus.busy}, 32'd0);
    rst = 1'b0;
    tick();
    chk("post_reset_busy", {31'd0, bus.busy}, 32'd0);

    // Transfers, TAY back-to-back right after TAX
    preload(8'h00, 8'h00, 8'h5A, 8'hFD);
    xfer("tax", 8'hAA, M_AEN | M_XLD | M_DONE | M_NZ, 8'h5A);
    chk("tax_x", {24'd0, m_x}, 32'h5A);
    xfer("tay", 8'hA8, M_AEN | M_YLD | M_DONE | M_NZ, 8'h5A);
    chk("tay_y", {24'd0, m_y}, 32'h5A);
    preload(8'h00, 8'h00, 8'h00, 8'h80);
    xfer("tsx", 8'hBA, M_SEN | M_XLD | M_DONE | M_NZ, 8'h80);
    xfer("txa", 8'h8A, M_XEN | M_ALD | M_DAA | M_DONE | M_NZ, 8'h80);
    chk("txa_a", {24'd0, m_a}, 32'h80);
    xfer("tya", 8'h98, M_YEN | M_ALD | M_DAA | M_DONE | M_NZ, 8'h00);
    preload(8'hFF, 8'h00, 8'h00, 8'h00);
    xfer("txs", 8'h9A, M_XEN | M_SLD | M_DONE, 8'hFF);
    chk("txs_s", {24'd0, m_s}, 32'hFF);

    // Increment/decrement wrap
    preload(8'hFF, 8'h00, 8'h00, 8'h00);
    incdec("inx", 8'hE8, M_XEN | M_AI | M_CDB | M_BI | M_CI,
           M_ADD | M_XLD | M_DONE | M_NZ | M_CI, 8'h00);
    chk("inx_x", {24'd0, m_x}, 32'h00);
    incdec("dey", 8'h88, M_YEN | M_AI | M_CDB | M_BINV,
           M_ADD | M_YLD | M_DONE | M_NZ, 8'hFF);
    chk("dey_y", {24'd0, m_y}, 32'hFF);

    // INY with three stalled write-back cycles
    preload(8'h00, 8'h41, 8'h00, 8'h00);
    y_before = y_loads;
    push("iny_ld", M_YEN | M_AI | M_CDB | M_BI | M_CI, cyc + 1, 1'b0, 8'h00);
    push("iny_wb", M_ADD | M_YLD | M_DONE | M_NZ | M_CI, cyc + 5, 1'b1, 8'h42);
    issue(8'hC8);
    tick();
    bus.rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_busy", {31'd0, bus.busy}, 32'd1);
      chk("stall_ci", {31'd0, bus.alu_ci}, 32'd1);
      tick();
    end
    bus.rdy = 1'b1;
    tick();
    chk("iny_idle", {31'd0, bus.busy}, 32'd0);
    chk("iny_y", {24'd0, m_y}, 32'h42);
    chk("iny_single_load", y_loads - y_before, 32'd1);

    // Illegal opcode
    push("ill", M_ILL, cyc + 1, 1'b0, 8'h00);
    issue(8'hEA);
    chk("ill_busy", {31'd0, bus.busy}, 32'd0);
    tick();
    chk("ill_one_cycle", {31'd0, bus.illegal}, 32'd0);

    // TXA requested while DEX is busy is dropped
    preload(8'h10, 8'h00, 8'h33, 8'h00);
    push("dex_ld", M_XEN | M_AI | M_CDB | M_BINV, cyc + 1, 1'b0, 8'h00);
    push("dex_wb", M_ADD | M_XLD | M_DONE | M_NZ, cyc + 2, 1'b1, 8'h0F);
    issue(8'hCA);
    issue(8'h8A);
    tick();
    chk("dex_idle", {31'd0, bus.busy}, 32'd0);
    chk("dex_x", {24'd0, m_x}, 32'h0F);
    chk("overlap_a_kept", {24'd0, m_a}, 32'h33);

    // Asynchronous reset in the middle of INX's ALU_LD cycle
    issue(8'hE8);
    chk("rst_pre_ld", {14'd0, observe() & M_AI}, {14'd0, M_AI});
    #1 rst = 1'b1;
    #1 chk("rst_async_clear", {13'd0, observe(), bus.busy}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("rst_release_idle", {31'd0, bus.busy}, 32'd0);

    for (int i = 0; i < 20 && q.size() != 0; i++) tick();
    chk("queue_drained", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
